// File: rtl/voltage_display_pkg.sv
// Shared types and default constants for the two-channel voltage display formatter.
package voltage_display_pkg;

  localparam int VREF_MV    = 3300;
  localparam int ADC_BITS   = 10;
  localparam int MV_BITS    = 12;
  localparam int BCD_DIGITS = 4;

  typedef enum logic [2:0] {
    IDLE,
    SCALE,
    SHIFT,
    STORE,
    DONE
  } state_t;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bin_to_bcd_serial.sv
// Serial double-dabble: load a binary value, then one MSB-first shift per enabled cycle.
module bin_to_bcd_serial
  import voltage_display_pkg::*;
#(
  parameter int BIN_BITS = MV_BITS
) (
  input  logic                      i_clk,
  input  logic                      i_load,
  input  logic                      i_shift,
  input  logic [BIN_BITS-1:0]       i_bin,
  output logic [BCD_DIGITS*4-1:0]   o_bcd
);

  localparam int BCD_W = BCD_DIGITS * 4;

  logic [BIN_BITS-1:0] r_bin;
  logic [BCD_W-1:0]    r_bcd;
  logic [BCD_W-1:0]    w_adj;

  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

  assign w_adj = add3_digits(r_bcd);

  always_ff @(posedge i_clk) begin
    if (i_load) begin
      r_bin <= i_bin;
      r_bcd <= '0;
    end else if (i_shift) begin
      {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
    end
  end

  assign o_bcd = r_bcd;

endmodule

// File: rtl/voltage_bcd_formatter.sv
// Scales two ADC readings to millivolts and formats them as V.VVV BCD digits
// for an 8-digit multiplexed display; both channels update together.
module voltage_bcd_formatter #(
  parameter int VREF_MV  = voltage_display_pkg::VREF_MV,
  parameter int ADC_BITS = voltage_display_pkg::ADC_BITS,
  parameter int MV_BITS  = voltage_display_pkg::MV_BITS
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [ADC_BITS-1:0] i_reading1,
  input  logic [ADC_BITS-1:0] i_reading2,
  output logic                o_busy,
  output logic                o_done,
  output logic [3:0]          o_numbers [0:7],
  output logic                o_dots [0:7]
);

  import voltage_display_pkg::*;

  localparam int PROD_W = ADC_BITS + $clog2(VREF_MV + 1);
  localparam int CNT_W  = $clog2(MV_BITS);
  localparam int BCD_W  = BCD_DIGITS * 4;

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic                r_ch;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADC_BITS-1:0] r_rd1;
  logic [ADC_BITS-1:0] r_rd2;
  logic [BCD_W-1:0]    r_shadow1;
  bcd_digit_t          r_numbers [0:7];

  logic [ADC_BITS-1:0] w_sel;
  logic [PROD_W-1:0]   w_prod;
  logic [MV_BITS-1:0]  w_mv;
  logic [BCD_W-1:0]    w_bcd;
  logic                w_load;
  logic                w_shift;

  // Scaling truncates toward zero: full-scale code maps just below VREF_MV.
  assign w_sel   = r_ch ? r_rd2 : r_rd1;
  assign w_prod  = PROD_W'(w_sel) * PROD_W'(VREF_MV);
  assign w_mv    = MV_BITS'(w_prod >> ADC_BITS);
  assign w_load  = (r_state == SCALE);
  assign w_shift = (r_state == SHIFT);

  bin_to_bcd_serial #(
    .BIN_BITS (MV_BITS)
  ) u_bcd (
    .i_clk   (i_clk),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_bin   (w_mv),
    .o_bcd   (w_bcd)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_numbers[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_rd1   <= i_reading1;
            r_rd2   <= i_reading2;
            r_ch    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= SCALE;
          end
        end
        SCALE: begin
          r_cnt   <= '0;
          r_state <= SHIFT;
        end
        SHIFT: begin
          if (r_cnt == CNT_W'(MV_BITS - 1)) begin
            r_state <= STORE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STORE: begin
          if (!r_ch) begin
            r_shadow1 <= w_bcd;
            r_ch      <= 1'b1;
            r_state   <= SCALE;
          end else begin
            // Channel 2 goes straight out so all eight digits change on one edge.
            for (int i = 0; i < BCD_DIGITS; i++) begin
              r_numbers[4 + i] <= r_shadow1[4*i +: 4];
              r_numbers[i]     <= w_bcd[4*i +: 4];
            end
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_numbers = r_numbers;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      o_dots[i] = (i == 3) || (i == 7);
    end
  end

endmodule

// File: tb/tb_voltage_bcd_formatter.sv
// Bench for voltage_bcd_formatter: fixed vectors, corner sequences and random conversions.
module tb_voltage_bcd_formatter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] rd1;
  logic [9:0] rd2;
  logic       busy;
  logic       done;
  logic [3:0] nums [0:7];
  logic       dots [0:7];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [9:0]  r1;
    logic [9:0]  r2;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [7];

  voltage_bcd_formatter dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_reading1 (rd1),
    .i_reading2 (rd2),
    .o_busy     (busy),
    .o_done     (done),
    .o_numbers  (nums),
    .o_dots     (dots)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] packed_nums();
    logic [31:0] v;
    for (int i = 0; i < 8; i++) v[4*i +: 4] = nums[i];
    return v;
  endfunction

  function automatic logic [31:0] packed_dots();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i] = dots[i];
    return v;
  endfunction

  function automatic logic [15:0] digits(input int mv);
    return {4'(mv / 1000), 4'((mv / 100) % 10), 4'((mv / 10) % 10), 4'(mv % 10)};
  endfunction

  // Reference: millivolts by plain integer arithmetic, then decimal digits.
  function automatic logic [31:0] ref_model(input int a, input int b);
    return {digits(a * 3300 / 1024), digits(b * 3300 / 1024)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Runs one conversion starting in the next cycle; optional re-start and input change.
  task automatic conv(input logic [9:0] a, input logic [9:0] b, input logic [31:0] exp,
                      input int again_k, input int chg_k, input string tag);
    @(negedge clk);
    chk({tag, " busy before start"}, 32'(busy), 32'(0));
    rd1   = a;
    rd2   = b;
    start = 1'b1;
    for (int k = 1; k <= 29; k++) begin
      @(negedge clk);
      start = (k == again_k);
      if (k == chg_k) begin
        rd1 = ~a;
        rd2 = ~b;
      end
      chk({tag, " done"}, 32'(done), 32'(k == 29));
      chk({tag, " busy"}, 32'(busy), 32'(1));
      chk({tag, " dots"}, packed_dots(), 32'h88);
      if (k == 29) chk({tag, " digits"}, packed_nums(), exp);
    end
    start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{10'd0,    10'd1023, 32'h0000_3296};
    vecs[1] = '{10'd512,  10'd310,  32'h1650_0999};
    vecs[2] = '{10'd1,    10'd1,    32'h0003_0003};
    vecs[3] = '{10'd1023, 10'd0,    32'h3296_0000};
    vecs[4] = '{10'd100,  10'd777,  32'h0322_2504};
    vecs[5] = '{10'd1023, 10'd1023, 32'h3296_3296};
    vecs[6] = '{10'd310,  10'd512,  32'h0999_1650};

    rst   = 1'b1;
    start = 1'b0;
    rd1   = '0;
    rd2   = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 32'(0));
    chk("reset done", 32'(done), 32'(0));
    chk("reset digits", packed_nums(), 32'h0);
    chk("reset dots", packed_dots(), 32'h88);
    rst = 1'b0;

    // Table runs back-to-back: each start lands in the cycle after the previous done.
    for (int i = 0; i < 7; i++) begin
      conv(vecs[i].r1, vecs[i].r2, vecs[i].exp, 0, 0, $sformatf("vec%0d", i));
    end

    // Start while busy must be ignored.
    conv(10'd512, 10'd310, 32'h1650_0999, 5, 0, "restart");
    @(negedge clk);
    chk("restart busy c30", 32'(busy), 32'(0));
    for (int k = 0; k < 34; k++) begin
      @(negedge clk);
      chk("restart no 2nd done", 32'(done), 32'(0));
    end

    // Readings change after capture.
    conv(10'd700, 10'd45, ref_model(700, 45), 0, 3, "change");

    // Reset mid-conversion, with a start held during reset.
    @(negedge clk);
    rd1   = 10'd900;
    rd2   = 10'd123;
    start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk("abort done", 32'(done), 32'(0));
      if (k == 10) rst = 1'b1;
    end
    start = 1'b1;
    @(negedge clk);
    chk("abort busy", 32'(busy), 32'(0));
    chk("abort done after rst", 32'(done), 32'(0));
    chk("abort digits cleared", packed_nums(), 32'h0);
    @(negedge clk);
    chk("rst over start busy", 32'(busy), 32'(0));
    rst   = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      chk("abort no done", 32'(done), 32'(0));
      chk("abort digits hold", packed_nums(), 32'h0);
    end
    conv(10'd900, 10'd123, ref_model(900, 123), 0, 0, "after abort");

    for (int n = 0; n < 40; n++) begin
      logic [9:0] a;
      logic [9:0] b;
      int again;
      int chg;
      a     = 10'($urandom_range(0, 1023));
      b     = 10'($urandom_range(0, 1023));
      again = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 28)) : 0;
      chg   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 28)) : 0;
      conv(a, b, ref_model(int'(a), int'(b)), again, chg, $sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
